clk_run_ctrl: RTL

Run controller between the board clock input and the single-cycle CPU core. It generates the CPU clock enable, counts executed cycles, and stops execution on a cycle budget, a CPU halt, or a host STOP command. It puts the simulation-only "run N clocks then stop" behaviour into synthesizable hardware, driven by a valid/ready command port.

---
 rtl/clk_run_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/clk_run_ctrl.sv
// clk_run_ctrl: run controller between the board clock and the CPU core.
// Generates the CPU clock enable, counts executed cycles and ends a run
// on a cycle budget, a CPU halt or a host STOP command.
module clk_run_ctrl #(
  parameter int unsigned CNT_W         = 22,
  parameter int unsigned DEFAULT_LIMIT = 500
) (
  input  logic             inclk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             cpu_halt,
  output logic             cpu_ce,
  output logic             running,
  output logic             done,
  output logic [1:0]       done_cause,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RUN_LIM = 2'd2,
    ST_STEP    = 2'd3
  } state_e;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_RUN_N = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [1:0] CAUSE_LIMIT = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_STOP  = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEFAULT_LIMIT);

  state_e           state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             ready_q, ready_d;

  logic accept_s;
  logic halt_end_s;
  logic stop_end_s;
  logic limit_end_s;
  logic step_end_s;

  // ready is registered from the next state, but forced low while reset is held
  assign cmd_ready   = ready_q & ~rst;
  assign accept_s    = cmd_valid & cmd_ready;
  assign cpu_ce      = cpu_ce_q;
  assign running     = running_q;
  assign done        = done_q;
  assign done_cause  = cause_q;
  assign cycle_count = count_q;

  // Next-state, budget, counter and end-of-run resolution
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    cause_d     = cause_q;
    done_d      = 1'b0;

    // cpu_halt only matters in cycles the CPU actually executes
    halt_end_s  = cpu_ce_q & cpu_halt;
    stop_end_s  = accept_s & (cmd_op == OP_STOP) &
                  ((state_q == ST_RUN) | (state_q == ST_RUN_LIM));
    limit_end_s = (state_q == ST_RUN_LIM) & (remaining_q == ONE);
    step_end_s  = (state_q == ST_STEP);

    // executed cycles are counted; the counter wraps naturally
    if (cpu_ce_q) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              count_d = ZERO;
            end
            OP_RUN_N: begin
              state_d = ST_RUN_LIM;
              count_d = ZERO;
              if (cmd_arg == ZERO) begin
                remaining_d = DEF_LIM;
              end else begin
                remaining_d = cmd_arg;
              end
            end
            OP_STEP: begin
              // single step keeps accumulating cycle_count
              state_d = ST_STEP;
            end
            default: begin
              // STOP while idle is accepted and dropped
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN_LIM: begin
        // cpu_ce is always high in this state, so the budget burns every cycle
        remaining_d = remaining_q - ONE;
      end
      default: begin
        remaining_d = remaining_q;
      end
    endcase

    // one done pulse per run; halt > stop > limit > step
    if (halt_end_s | stop_end_s | limit_end_s | step_end_s) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      if (halt_end_s) begin
        cause_d = CAUSE_HALT;
      end else if (stop_end_s) begin
        cause_d = CAUSE_STOP;
      end else if (limit_end_s) begin
        cause_d = CAUSE_LIMIT;
      end else begin
        cause_d = CAUSE_STEP;
      end
    end else begin
      done_d  = 1'b0;
      cause_d = cause_q;
    end

    cpu_ce_d  = (state_d != ST_IDLE);
    running_d = (state_d == ST_RUN) | (state_d == ST_RUN_LIM);
    ready_d   = (state_d != ST_STEP);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge inclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cpu_ce_q    <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'd0;
      count_q     <= ZERO;
      remaining_q <= ZERO;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cpu_ce_q    <= cpu_ce_d;
      running_q   <= running_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      ready_q     <= ready_d;
    end
  end

endmodule
